// File: rtl/mem_instr_loader.sv
// Framed byte-stream loader: parses A5|BASE|N|payload|CSUM, writes payload to
// instruction memory and holds the core in reset until a frame is accepted.
`ifndef XLEN_32b
`define XLEN_32b 1
`endif
`ifndef XLEN_64b
`define XLEN_64b 2
`endif

module mem_instr_loader #(
    parameter int unsigned XLEN           = `XLEN_64b,
    parameter int unsigned MEM_BYTES_LOG2 = 20,
    localparam int unsigned ADR_W         = 1 << (XLEN + 4)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [7:0]       i_byte,
    input  logic             i_byte_valid,
    output logic             o_byte_ready,
    output logic             o_we,
    output logic [ADR_W-1:0] o_wr_adr,
    output logic [7:0]       o_wr_byte,
    output logic             o_core_rst,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    localparam logic [7:0]  MAGIC    = 8'hA5;
    localparam int unsigned CNT_W    = 18;
    localparam logic [33:0] MEM_SIZE = 34'(64'(1) << MEM_BYTES_LOG2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t               r_state;
    logic [31:0]          r_base;
    logic [15:0]          r_n;
    logic [CNT_W-1:0]     r_cnt;
    logic [7:0]           r_xor;
    logic                 r_byte_ready;
    logic                 r_we;
    logic [ADR_W-1:0]     r_wr_adr;
    logic [7:0]           r_wr_byte;
    logic                 r_core_rst;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;

    logic                 w_xfer;
    logic [15:0]          w_n_full;
    logic [33:0]          w_end;
    logic                 w_hdr_bad;
    logic                 w_data_last;

    assign w_xfer      = i_byte_valid && r_byte_ready;
    // N as it stands once the second length byte lands this cycle
    assign w_n_full    = {i_byte, r_n[15:8]};
    assign w_end       = 34'(r_base) + {16'd0, w_n_full, 2'b00};
    assign w_hdr_bad   = (r_base[1:0] != 2'b00)
                      || ((r_base >> MEM_BYTES_LOG2) != 32'd0)
                      || (w_end > MEM_SIZE);
    assign w_data_last = (r_cnt + 18'd1) == {r_n, 2'b00};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_base       <= '0;
            r_n          <= '0;
            r_cnt        <= '0;
            r_xor        <= '0;
            r_byte_ready <= 1'b1;
            r_we         <= 1'b0;
            r_wr_adr     <= '0;
            r_wr_byte    <= '0;
            r_core_rst   <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_xfer && i_byte == MAGIC) begin
                        r_state    <= S_ADDR;
                        r_busy     <= 1'b1;
                        r_core_rst <= 1'b1;
                        r_base     <= '0;
                        r_n        <= '0;
                        r_xor      <= '0;
                        r_cnt      <= '0;
                    end
                end
                S_ADDR: begin
                    if (w_xfer) begin
                        r_base <= {i_byte, r_base[31:8]};
                        if (r_cnt == 18'd3) begin
                            r_cnt   <= '0;
                            r_state <= S_LEN;
                        end else begin
                            r_cnt <= r_cnt + 18'd1;
                        end
                    end
                end
                S_LEN: begin
                    if (w_xfer) begin
                        r_n <= w_n_full;
                        if (r_cnt == 18'd1) begin
                            r_cnt <= '0;
                            if (w_hdr_bad) begin
                                r_state      <= S_ERR;
                                r_byte_ready <= 1'b0;
                                r_busy       <= 1'b0;
                                r_err        <= 1'b1;
                            end else if (w_n_full == 16'd0) begin
                                r_state <= S_CSUM;
                            end else begin
                                r_state <= S_DATA;
                            end
                        end else begin
                            r_cnt <= r_cnt + 18'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_we      <= 1'b1;
                        r_wr_adr  <= ADR_W'(r_base) + ADR_W'(r_cnt);
                        r_wr_byte <= i_byte;
                        r_xor     <= r_xor ^ i_byte;
                        if (w_data_last) begin
                            r_cnt   <= '0;
                            r_state <= S_CSUM;
                        end else begin
                            r_cnt <= r_cnt + 18'd1;
                        end
                    end
                end
                S_CSUM: begin
                    if (w_xfer) begin
                        r_byte_ready <= 1'b0;
                        r_busy       <= 1'b0;
                        if (i_byte == r_xor) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state      <= S_IDLE;
                    r_byte_ready <= 1'b1;
                    r_core_rst   <= 1'b0;
                end
                S_ERR: begin
                    r_state <= S_ERR;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_byte_ready <= 1'b1;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign o_byte_ready = r_byte_ready;
    assign o_we         = r_we;
    assign o_wr_adr     = r_wr_adr;
    assign o_wr_byte    = r_wr_byte;
    assign o_core_rst   = r_core_rst;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;

endmodule

// File: tb/tb_mem_instr_loader.sv
// Bench for mem_instr_loader: frame-level reference model, write scoreboard and
// per-cycle comparison of every output against expected flags.
module tb_mem_instr_loader;

    localparam int unsigned ADR_W = 64;

    logic             clk = 1'b0;
    logic             i_rst;
    logic [7:0]       i_byte;
    logic             i_byte_valid;
    logic             o_byte_ready;
    logic             o_we;
    logic [ADR_W-1:0] o_wr_adr;
    logic [7:0]       o_wr_byte;
    logic             o_core_rst;
    logic             o_busy;
    logic             o_done;
    logic             o_err;

    mem_instr_loader dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_byte       (i_byte),
        .i_byte_valid (i_byte_valid),
        .o_byte_ready (o_byte_ready),
        .o_we         (o_we),
        .o_wr_adr     (o_wr_adr),
        .o_wr_byte    (o_wr_byte),
        .o_core_rst   (o_core_rst),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] adr;
        logic [7:0]  b;
    } wr_t;

    wr_t        sbq[$];
    logic [7:0] mem [logic [63:0]];
    int         n_checks = 0;
    int         n_err = 0;
    int         wr_count = 0;
    int         done_count = 0;
    int         gap_max = 0;
    bit         chk_en = 1'b0;
    logic       exp_ready, exp_busy, exp_done, exp_err, exp_core_rst;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [63:0] a);
        return {mem[a + 64'd3], mem[a + 64'd2], mem[a + 64'd1], mem[a]};
    endfunction

    // Per-cycle comparison against the model's expected flags and write queue
    always @(negedge clk) begin
        if (chk_en) begin
            if (o_we) begin
                wr_count++;
                mem[o_wr_adr] = o_wr_byte;
                if (sbq.size() == 0) begin
                    chk("unexpected_we", 64'(o_wr_adr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    wr_t e;
                    e = sbq.pop_front();
                    chk("wr_adr", o_wr_adr, e.adr);
                    chk("wr_byte", 64'(o_wr_byte), 64'(e.b));
                end
            end
            if (o_done) done_count++;
            chk("byte_ready", 64'(o_byte_ready), 64'(exp_ready));
            chk("busy", 64'(o_busy), 64'(exp_busy));
            chk("done", 64'(o_done), 64'(exp_done));
            chk("err", 64'(o_err), 64'(exp_err));
            chk("core_rst", 64'(o_core_rst), 64'(exp_core_rst));
        end
    end

    task automatic set_reset_expect();
        exp_ready    = 1'b1;
        exp_busy     = 1'b0;
        exp_done     = 1'b0;
        exp_err      = 1'b0;
        exp_core_rst = 1'b1;
        sbq.delete();
    endtask

    task automatic do_reset();
        i_rst        = 1'b1;
        i_byte_valid = 1'b0;
        @(posedge clk); #1;
        i_rst = 1'b0;
        set_reset_expect();
    endtask

    // Offer one byte (after an optional idle gap) and wait for the handshake
    task automatic xfer(input logic [7:0] b, output bit ok);
        bit rdy;
        ok = 1'b0;
        repeat ($urandom_range(gap_max, 0)) begin
            i_byte_valid = 1'b0;
            @(posedge clk); #1;
        end
        i_byte       = b;
        i_byte_valid = 1'b1;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            rdy = o_byte_ready;
            @(posedge clk); #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        i_byte_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_err++;
            $display("FAIL xfer_timeout byte=%02h not accepted", b);
        end
    endtask

    task automatic send_frame(input logic [31:0] base, input logic [15:0] n,
                              input logic [7:0] pl[$], input logic [7:0] cs_flip,
                              input int abort_at);
        logic [7:0]  hdr[$];
        logic [7:0]  cs;
        logic [63:0] last;
        bit          ok;
        hdr = '{base[7:0], base[15:8], base[23:16], base[31:24], n[7:0], n[15:8]};
        xfer(8'hA5, ok);
        if (!ok) return;
        exp_busy     = 1'b1;
        exp_core_rst = 1'b1;
        foreach (hdr[i]) begin
            xfer(hdr[i], ok);
            if (!ok) return;
        end
        last = 64'(base) + 64'(n) * 64'd4;
        if (base[1:0] != 2'b00 || base >= 32'h0010_0000 || last > 64'h10_0000) begin
            exp_err   = 1'b1;
            exp_ready = 1'b0;
            exp_busy  = 1'b0;
            return;
        end
        for (int k = 0; k < 4 * int'(n); k++)
            sbq.push_back('{adr: 64'(base) + 64'(k), b: pl[k]});
        cs = 8'h00;
        for (int k = 0; k < 4 * int'(n); k++) begin
            if (k == abort_at) begin
                do_reset();
                return;
            end
            xfer(pl[k], ok);
            if (!ok) return;
            cs ^= pl[k];
        end
        xfer(cs ^ cs_flip, ok);
        if (!ok) return;
        if (cs_flip == 8'h00) begin
            exp_done  = 1'b1;
            exp_busy  = 1'b0;
            exp_ready = 1'b0;
            // A byte offered during the accept cycle must be held, then eaten in IDLE
            i_byte       = 8'h00;
            i_byte_valid = 1'b1;
            @(posedge clk); #1;
            exp_done     = 1'b0;
            exp_ready    = 1'b1;
            exp_core_rst = 1'b0;
            @(posedge clk); #1;
            i_byte_valid = 1'b0;
            chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        end else begin
            exp_err   = 1'b1;
            exp_ready = 1'b0;
            exp_busy  = 1'b0;
        end
    endtask

    task automatic send_garbage(input int cnt);
        bit         ok;
        logic [7:0] g;
        for (int i = 0; i < cnt; i++) begin
            g = 8'($urandom);
            if (g == 8'hA5) g = 8'h5A;
            xfer(g, ok);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  pl[$];
        logic [7:0]  ga[$];
        bit          ok;
        int          w0, d0, kind, n;
        logic [31:0] base;

        i_rst        = 1'b1;
        i_byte       = 8'h00;
        i_byte_valid = 1'b0;
        set_reset_expect();
        repeat (3) @(posedge clk);
        #1;
        i_rst  = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_we", 64'(o_we), 64'd0);
        chk("rst_wr_adr", o_wr_adr, 64'd0);
        chk("rst_wr_byte", 64'(o_wr_byte), 64'd0);
        chk("rst_ready", 64'(o_byte_ready), 64'd1);
        chk("rst_core_rst", 64'(o_core_rst), 64'd1);
        @(posedge clk); #1;

        // Garbage then the reference good frame
        ga = '{8'h00, 8'hFF, 8'h5A};
        foreach (ga[i]) xfer(ga[i], ok);
        pl = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        w0 = wr_count;
        d0 = done_count;
        send_frame(32'h0004_0000, 16'd2, pl, 8'h00, -1);
        chk("frameA_writes", 64'(wr_count - w0), 64'd8);
        chk("frameA_done_pulses", 64'(done_count - d0), 64'd1);
        chk("frameA_word0", 64'(rd_word(64'h4_0000)), 64'h0000_0013);
        chk("frameA_word1", 64'(rd_word(64'h4_0004)), 64'h0010_0093);
        chk("frameA_core_rst", 64'(o_core_rst), 64'd0);

        // Same frame, bad checksum: writes stay, error sticks, input stalls
        w0 = wr_count;
        send_frame(32'h0004_0000, 16'd2, pl, 8'h01, -1);
        i_byte = 8'hA5;
        i_byte_valid = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        i_byte_valid = 1'b0;
        chk("badcs_writes", 64'(wr_count - w0), 64'd8);
        chk("badcs_err", 64'(o_err), 64'd1);
        chk("badcs_core_rst", 64'(o_core_rst), 64'd1);
        chk("badcs_ready", 64'(o_byte_ready), 64'd0);
        do_reset();

        // Header check failures
        w0 = wr_count;
        send_frame(32'h0004_0002, 16'd2, pl, 8'h00, -1);
        @(posedge clk); #1;
        chk("misaligned_writes", 64'(wr_count - w0), 64'd0);
        chk("misaligned_err", 64'(o_err), 64'd1);
        do_reset();
        w0 = wr_count;
        send_frame(32'h000F_FFFC, 16'd2, pl, 8'h00, -1);
        @(posedge clk); #1;
        chk("overflow_writes", 64'(wr_count - w0), 64'd0);
        chk("overflow_err", 64'(o_err), 64'd1);
        do_reset();

        // Empty payload
        pl.delete();
        w0 = wr_count;
        d0 = done_count;
        send_frame(32'h0000_0010, 16'd0, pl, 8'h00, -1);
        chk("n0_writes", 64'(wr_count - w0), 64'd0);
        chk("n0_done_pulses", 64'(done_count - d0), 64'd1);
        chk("n0_core_rst", 64'(o_core_rst), 64'd0);

        // Reset after three payload bytes, then a clean frame
        pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        w0 = wr_count;
        send_frame(32'h0000_0200, 16'd2, pl, 8'h00, 3);
        @(negedge clk);
        chk("abort_writes", 64'(wr_count - w0), 64'd3);
        chk("abort_busy", 64'(o_busy), 64'd0);
        chk("abort_core_rst", 64'(o_core_rst), 64'd1);
        @(posedge clk); #1;
        w0 = wr_count;
        send_frame(32'h0000_0200, 16'd2, pl, 8'h00, -1);
        chk("after_abort_writes", 64'(wr_count - w0), 64'd8);
        chk("after_abort_word1", 64'(rd_word(64'h204)), 64'h8877_6655);

        // Randomised frames with valid gaps and occasional faults
        gap_max = 2;
        for (int f = 0; f < 30; f++) begin
            send_garbage($urandom_range(2, 0));
            kind = ($urandom_range(5, 0) < 3) ? 0 : int'($urandom_range(3, 1));
            n    = (kind == 3) ? int'($urandom_range(6, 1)) : int'($urandom_range(6, 0));
            base = 32'($urandom_range(32'h3_FFF0, 0)) << 2;
            if (kind == 2) base = base | 32'($urandom_range(3, 1));
            if (kind == 3) base = 32'h10_0000 - 32'(4 * n) + 32'h4;
            pl.delete();
            for (int k = 0; k < 4 * n; k++) pl.push_back(8'($urandom));
            w0 = wr_count;
            send_frame(base, 16'(n), pl, (kind == 1) ? 8'($urandom_range(255, 1)) : 8'h00, -1);
            @(posedge clk); #1;
            chk("rand_writes", 64'(wr_count - w0), (kind <= 1) ? 64'(4 * n) : 64'd0);
            if (kind != 0) do_reset();
        end

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
